time_field_editor: RTL and testbench

Generalised successor to the single-shot H/M/S setting block.
- Holds NFIELDS editable fields of W bits each. Each field has its own runtime lower and upper limits.
- Buttons move a cursor between fields and increment or decrement the selected field, with auto-repeat while a button is held.
- Field 0 can toggle AM/PM when it wraps.
- Sits between the RTC read path and the RTC write path. When editing ends it emits a one-cycle commit pulse to the register-write sequencer.

---
 rtl/time_field_editor.sv | 159 +++++++++++++++
 tb/tb_time_field_editor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_field_editor.sv
// time_field_editor: cursor-driven editor for NFIELDS packed W-bit fields.
// Tracks the RTC values while idle. Captures them when editing starts.
// Steps the selected field within per-field runtime limits, with auto-repeat.
// Pulses commit for one cycle when the edit session ends.
module time_field_editor #(
    parameter int NFIELDS    = 3,
    parameter int W          = 8,
    parameter int SELW       = 2,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000,
    parameter int CNTW       = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 format,
    input  logic [NFIELDS*W-1:0] val_in,
    input  logic                 ampm_in,
    input  logic [NFIELDS*W-1:0] lo_lim,
    input  logic [NFIELDS*W-1:0] hi_lim,
    input  logic                 bt_up,
    input  logic                 bt_down,
    input  logic                 bt_left,
    input  logic                 bt_right,
    output logic [NFIELDS*W-1:0] val_out,
    output logic                 ampm_out,
    output logic [SELW-1:0]      sel,
    output logic                 editing,
    output logic                 commit,
    output logic [1:0]           fsm_state
);

    // Encoding is visible on fsm_state: IDLE=0, LOAD=1, EDIT=2.
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EDIT = 2'd2} state_t;

    localparam logic [CNTW-1:0] CNT_FIRE   = CNTW'(RPT_DELAY - 1);
    localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(RPT_DELAY - RPT_PERIOD);
    localparam logic [SELW-1:0] SEL_MAX    = SELW'(NFIELDS - 1);

    // Handshake: none. Buttons are debounced levels. Only a rising edge
    // (level high, previous level low) counts as a press.

    state_t          state;
    logic            fmt_q;
    logic            up_q, down_q, left_q, right_q;
    logic [CNTW-1:0] cnt;

    logic [W-1:0]    cur_fld [NFIELDS];
    logic [W-1:0]    lo_fld  [NFIELDS];
    logic [W-1:0]    hi_fld  [NFIELDS];

    logic            up_edge, down_edge, left_edge, right_edge;
    logic            one_held, move, cnt_clear, rpt_fire, do_step, wrap, toggle;
    logic [W-1:0]    cur_v, lo_v, hi_v, nxt_v;
    logic [SELW-1:0] sel_next;

    assign fsm_state = state;

    // Unpack the flat buses so the selected field can be indexed by sel.
    for (genvar i = 0; i < NFIELDS; i++) begin : g_unpack
        assign cur_fld[i] = val_out[i*W +: W];
        assign lo_fld[i]  = lo_lim[i*W +: W];
        assign hi_fld[i]  = hi_lim[i*W +: W];
    end

    // Press detection, repeat timing, step value and cursor target.
    always_comb begin
        up_edge    = bt_up & ~up_q;
        down_edge  = bt_down & ~down_q;
        left_edge  = bt_left & ~left_q;
        right_edge = bt_right & ~right_q;
        one_held   = bt_up ^ bt_down;
        move       = left_edge ^ right_edge;
        cnt_clear  = ~one_held | up_edge | down_edge | move;
        rpt_fire   = ~cnt_clear & (cnt == CNT_FIRE);
        do_step    = one_held & ((bt_up ? up_edge : down_edge) | rpt_fire);

        cur_v = cur_fld[sel];
        lo_v  = lo_fld[sel];
        hi_v  = hi_fld[sel];
        if (bt_up) begin
            wrap  = (cur_v >= hi_v);
            nxt_v = wrap ? lo_v : cur_v + W'(1);
        end else begin
            wrap  = (cur_v <= lo_v);
            nxt_v = wrap ? hi_v : cur_v - W'(1);
        end
        toggle = do_step & wrap & fmt_q & (sel == '0);

        sel_next = sel;
        if (right_edge && !left_edge) begin
            sel_next = (sel == SEL_MAX) ? '0 : sel + SELW'(1);
        end else if (left_edge && !right_edge) begin
            sel_next = (sel == '0) ? SEL_MAX : sel - SELW'(1);
        end
    end

    // Session FSM with registered outputs, button history and repeat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            val_out  <= '0;
            ampm_out <= 1'b0;
            sel      <= '0;
            editing  <= 1'b0;
            commit   <= 1'b0;
            fmt_q    <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            cnt      <= '0;
        end else begin
            up_q    <= bt_up;
            down_q  <= bt_down;
            left_q  <= bt_left;
            right_q <= bt_right;
            commit  <= 1'b0;
            case (state)
                IDLE: begin
                    val_out  <= val_in;
                    ampm_out <= ampm_in;
                    sel      <= '0;
                    editing  <= 1'b0;
                    cnt      <= '0;
                    if (en) state <= LOAD;
                end
                LOAD: begin
                    val_out  <= val_in;
                    ampm_out <= ampm_in;
                    fmt_q    <= format;
                    cnt      <= '0;
                    editing  <= 1'b1;
                    state    <= EDIT;
                end
                EDIT: begin
                    if (!en) begin
                        // val_out is left untouched so it shows the edit during commit.
                        state   <= IDLE;
                        editing <= 1'b0;
                        commit  <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        if (cnt_clear)     cnt <= '0;
                        else if (rpt_fire) cnt <= CNT_RELOAD;
                        else               cnt <= cnt + CNTW'(1);
                        for (int i = 0; i < NFIELDS; i++) begin
                            if (do_step && sel == SELW'(i)) val_out[i*W +: W] <= nxt_v;
                        end
                        if (toggle) ampm_out <= ~ampm_out;
                        sel <= sel_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_field_editor.sv
// tb_time_field_editor: directed test-plan steps followed by a randomized phase.
// All outputs are compared every cycle against a behavioural model of the editor.
module tb_time_field_editor;

    localparam int NF = 3;
    localparam int W  = 8;
    localparam int SW = 2;
    localparam int D  = 8;
    localparam int P  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1, en = 1'b0, format = 1'b1, ampm_in = 1'b0;
    logic bt_up = 1'b0, bt_down = 1'b0, bt_left = 1'b0, bt_right = 1'b0;
    logic [NF*W-1:0] val_in, lo_lim, hi_lim, val_out;
    logic ampm_out, editing, commit;
    logic [SW-1:0] sel;
    logic [1:0] fsm_state;

    int checks = 0;
    int failures = 0;

    // Model: session phase (0 idle, 1 load, 2 edit), field values, flags,
    // previous button levels and how long the current single hold has lasted.
    int m_st, m_amp, m_sel, m_fmt, m_commit, m_edit;
    int m_val [NF];
    int pu, pd, pl, pr, age;

    time_field_editor #(
        .NFIELDS(NF), .W(W), .SELW(SW), .RPT_DELAY(D), .RPT_PERIOD(P), .CNTW(25)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .format(format),
        .val_in(val_in), .ampm_in(ampm_in), .lo_lim(lo_lim), .hi_lim(hi_lim),
        .bt_up(bt_up), .bt_down(bt_down), .bt_left(bt_left), .bt_right(bt_right),
        .val_out(val_out), .ampm_out(ampm_out), .sel(sel),
        .editing(editing), .commit(commit), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic int fld(input logic [NF*W-1:0] bus, input int i);
        return int'(bus[i*W +: W]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply the editor rules to the inputs sampled at this clock edge.
    task automatic model_step();
        int nu, nd, nl, nr, ue, de, le, re, one, mv, fire, f, v, lo, hi, wrap;
        if (reset) begin
            m_st = 0; m_amp = 0; m_sel = 0; m_fmt = 0; m_commit = 0; m_edit = 0;
            for (int i = 0; i < NF; i++) m_val[i] = 0;
            pu = 0; pd = 0; pl = 0; pr = 0; age = 0;
            return;
        end
        nu = int'(bt_up); nd = int'(bt_down); nl = int'(bt_left); nr = int'(bt_right);
        ue = nu & ~pu & 1; de = nd & ~pd & 1; le = nl & ~pl & 1; re = nr & ~pr & 1;
        m_commit = 0;
        case (m_st)
            0: begin
                for (int i = 0; i < NF; i++) m_val[i] = fld(val_in, i);
                m_amp = int'(ampm_in); m_sel = 0; m_edit = 0; age = 0;
                if (en) m_st = 1;
            end
            1: begin
                for (int i = 0; i < NF; i++) m_val[i] = fld(val_in, i);
                m_amp = int'(ampm_in); m_fmt = int'(format); age = 0;
                m_edit = 1; m_st = 2;
            end
            default: begin
                if (!en) begin
                    m_st = 0; m_edit = 0; m_commit = 1; age = 0;
                end else begin
                    one = (nu != nd) ? 1 : 0;
                    mv = (le != re) ? 1 : 0;
                    fire = 0;
                    if (!one || ue || de || mv) age = 0;
                    else begin
                        age++;
                        fire = (age >= D && (age - D) % P == 0) ? 1 : 0;
                    end
                    if (one && (ue || de || fire)) begin
                        f = m_sel; v = m_val[f]; lo = fld(lo_lim, f); hi = fld(hi_lim, f); wrap = 0;
                        if (nu) begin
                            if (v >= hi) begin v = lo; wrap = 1; end else v = v + 1;
                        end else begin
                            if (v <= lo) begin v = hi; wrap = 1; end else v = v - 1;
                        end
                        m_val[f] = v;
                        if (wrap && f == 0 && m_fmt == 1) m_amp = 1 - m_amp;
                    end
                    if (re && !le) m_sel = (m_sel + 1) % NF;
                    else if (le && !re) m_sel = (m_sel + NF - 1) % NF;
                end
            end
        endcase
        pu = nu; pd = nd; pl = nl; pr = nr;
    endtask

    // One clock: update the model at the edge, compare every output 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < NF; i++) check($sformatf("val_out[%0d]", i), fld(val_out, i), m_val[i]);
        check("ampm_out", ampm_out, m_amp);
        check("sel", sel, m_sel);
        check("editing", editing, m_edit);
        check("commit", commit, m_commit);
        check("fsm_state", fsm_state, m_st);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        lo_lim = {8'd0, 8'd0, 8'd1};
        hi_lim = {8'd59, 8'd59, 8'd12};
        val_in = {8'd45, 8'd30, 8'd12};

        // Reset state
        ticks(2);
        check("reset_val_out", val_out, 0);
        check("reset_commit", commit, 0);
        reset = 1'b0;
        ticks(2);

        // Start a session, up wraps field 0 12->1 and toggles PM
        en = 1'b1; ticks(2);
        bt_up = 1'b1; tick();
        check("tp_up_f0", fld(val_out, 0), 1);
        check("tp_up_ampm", ampm_out, 1);
        bt_up = 1'b0; tick();
        bt_down = 1'b1; tick();
        check("tp_down_f0", fld(val_out, 0), 12);
        check("tp_down_ampm", ampm_out, 0);
        bt_down = 1'b0; tick();

        // Cursor movement and wrap
        bt_right = 1'b1; tick(); bt_right = 1'b0; tick();
        bt_right = 1'b1; tick(); bt_right = 1'b0; tick();
        bt_left = 1'b1; tick();
        check("tp_sel_121", sel, 1);
        bt_left = 1'b0; tick();
        bt_left = 1'b1; tick(); bt_left = 1'b0; tick();
        bt_left = 1'b1; tick();
        check("tp_sel_wrap_left", sel, 2);
        bt_left = 1'b0; tick();
        bt_left = 1'b1; bt_right = 1'b1; tick();
        check("tp_sel_both", sel, 2);
        bt_left = 1'b0; bt_right = 1'b0; tick();

        // Commit, then a new session with field 1 = 57 and an auto-repeat hold
        en = 1'b0; tick();
        check("tp_commit", commit, 1);
        val_in = {8'd45, 8'd57, 8'd1};
        tick();
        check("tp_after_commit", val_out, {8'd45, 8'd57, 8'd1});
        en = 1'b1; ticks(2);
        bt_right = 1'b1; tick(); bt_right = 1'b0; tick();
        bt_up = 1'b1; ticks(20);
        bt_up = 1'b0; tick();
        bt_up = 1'b1; bt_down = 1'b1; ticks(3);
        bt_up = 1'b0; bt_down = 1'b0; tick();

        // Up held across session start does not step until re-pressed
        bt_up = 1'b1; en = 1'b0; ticks(2);
        en = 1'b1; ticks(5);
        check("tp_held_load_f0", fld(val_out, 0), 1);
        bt_up = 1'b0; tick();
        bt_up = 1'b1; tick();
        check("tp_repress_f0", fld(val_out, 0), 2);
        bt_up = 1'b0; en = 1'b0; ticks(2);

        // 24 h mode: down from 0 wraps to 23 with ampm unchanged
        format = 1'b0; ampm_in = 1'b1;
        lo_lim = {8'd0, 8'd0, 8'd0};
        hi_lim = {8'd59, 8'd59, 8'd23};
        val_in = {8'd10, 8'd20, 8'd0};
        en = 1'b1; ticks(2);
        bt_down = 1'b1; tick();
        check("tp_24h_f0", fld(val_out, 0), 23);
        check("tp_24h_ampm", ampm_out, 1);
        bt_down = 1'b0; en = 1'b0; ticks(2);

        // Randomized sessions with out-of-range loads and changing limits
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 11) == 0) bt_up = ~bt_up;
            if ($urandom_range(0, 15) == 0) bt_down = ~bt_down;
            bt_left  = ($urandom_range(0, 9) == 0);
            bt_right = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) format = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) ampm_in = $urandom_range(0, 1);
            if ($urandom_range(0, 19) == 0) val_in = NF*W'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                for (int i = 0; i < NF; i++) begin
                    logic [W-1:0] a, b;
                    a = W'($urandom_range(0, 40));
                    b = W'($urandom_range(0, 40));
                    lo_lim[i*W +: W] = (a < b) ? a : b;
                    hi_lim[i*W +: W] = (a < b) ? b : a;
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; bt_up = 1'b0; bt_down = 1'b0; bt_left = 1'b0; bt_right = 1'b0;
        en = 1'b0; ticks(2);

        // Reset in the middle of an auto-repeat hold
        en = 1'b1; ticks(2);
        bt_up = 1'b1; ticks(10);
        reset = 1'b1; tick();
        check("tp_reset_val_out", val_out, 0);
        check("tp_reset_editing", editing, 0);
        check("tp_reset_commit", commit, 0);
        reset = 1'b0; bt_up = 1'b0; en = 1'b0; ticks(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
